adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin scheduler that shares one pipelined 32-bit adder (`adder`: ports `si`, `xout`, `ai`, `bi`, `xin`, `clk`, `rst`) between NREQ requesters. It issues at most one operation per cycle and encodes requester id and sequence number in the adder's 8-bit pass-through tag (`xin`/`xout`). It routes each returning sum to a shared result port, tracks in-flight operations, and provides a flush/drain handshake. It sits between requester front-ends and the adder instance; the adder shares this block's `clk`/`rst`.

## Interface
Parameters:
- NREQ, 4, number of requesters; fixed at 4, since the tag holds a 2-bit id.
- W, 32, operand and sum width.
- LAT, 5, adder latency in cycles from `xin`/`ai`/`bi` sampled to `xout`/`si` valid.

Ports (clock and reset first):
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot grant; at most one bit high.
- req_a  in  NREQ*W  operand A, requester k at bits [k*W +: W], signed.
- req_b  in  NREQ*W  operand B, same packing, signed.
- add_a  out  W  to adder `ai`.
- add_b  out  W  to adder `bi`.
- add_xin  out  8  to adder `xin`.
- add_si  in  W  from adder `si`.
- add_xout  in  8  from adder `xout`.
- res_valid  out  1  result strobe; there is no backpressure.
- res_id  out  2  requester id of the result.
- res_seq  out  5  per-requester sequence number of the result.
- res_sum  out  W  sum.
- flush  in  1  drain request, level.
- flush_done  out  1  pipeline empty, issue stopped.
- busy  out  1  inflight != 0 or state != RUN.
- err  out  1  sticky tag-protocol error.

## Operation
- Tag format: bit 7 is valid, bits [6:5] are the requester id, bits [4:0] are the sequence number. `8'h00` is a bubble.
- **Grant (combinational):**
  - Allowed only when state = RUN and `flush` = 0.
  - The winner is the first asserted `req_valid` searching from `ptr` upward, mod NREQ.
  - `req_ready[g]` = 1 for the winner only.
  - A transfer occurs when `req_valid[g]` and `req_ready[g]` are both high.
- **Issue:**
  - On a transfer: `add_a`/`add_b` = `req_a`/`req_b` of g, and `add_xin` = {1, g, seq_tx[g]}.
  - On clock: `seq_tx[g]` increments, wrapping 31 -> 0, and `ptr` <= (g+1) mod NREQ.
  - With no transfer: `add_a` = `add_b` = 0, `add_xin` = 0, and `ptr` holds.
- **Return:**
  - When `add_xout[7]` = 1, the registered result outputs load next edge: `res_valid` = 1, id = `xout[6:5]`, seq = `xout[4:0]`, sum = `add_si`.
  - `seq_rx[id]` increments.
  - Otherwise `res_valid` = 0 and the other result fields hold.
- **Inflight counter** (width clog2(LAT+2)):
  - +1 on issue, -1 on return, unchanged on both or neither.
  - Never exceeds LAT.
- **err** is set (and stays set until reset) when:
  - a return arrives with inflight = 0, or
  - the returned seq != `seq_rx[id]`.
- **FSM:**
  - RUN -> DRAIN when `flush` = 1.
  - DRAIN -> DONE when inflight = 0 and no return this cycle.
  - DONE -> RUN when `flush` = 0.
  - `flush_done` = 1 only in DONE (registered state decode).
  - No grants in DRAIN or DONE.
  - Flush with an empty pipeline: RUN -> DRAIN -> DONE on consecutive edges.
- Arithmetic wraps mod 2^W; overflow is not flagged.

## Timing
- Reset (asynchronous, active-low) forces:
  - `ptr` = 0, `seq_tx` = `seq_rx` = 0, inflight = 0, state = RUN;
  - `res_valid` = 0, `res_id` = 0, `res_seq` = 0, `res_sum` = 0;
  - `flush_done` = 0, `err` = 0, `busy` = 0.
- Reset mid-operation orphans in-flight operations. The adder must reset on the same `rst`, so no valid tag returns after release.
- Grant-to-`res_valid` latency is LAT+1 cycles. Issue rate is one operation per cycle; results return in issue order.
- `flush_done` rises one cycle after the last drained `res_valid`.
- `flush` asserted in the same cycle as a request: no grant.

## Structure
- Package `adder_sched_pkg` holds:
  - the tag field constants TAG_VLD = 7, TAG_ID_HI = 6, TAG_ID_LO = 5, TAG_SEQ_W = 5;
  - the FSM state enum {RUN, DRAIN, DONE}.
- Sub-module `rr_pick`: NREQ-bit request vector plus `ptr` in, one-hot grant plus index out; combinational only.

## Test plan
1. Single issue:
   - Stimulus: requester 0 sends a = -10, b = 10 at cycle 0.
   - Required: `add_xin` = 8'h80; `res_valid` at cycle LAT+1 with id 0, seq 0, sum 0; inflight back to 0.
2. Round-robin under full contention:
   - Stimulus: all four requesters valid continuously for 8 cycles (requester k: a = 352+k, b = 18).
   - Required: grant order 0,1,2,3,0,1,2,3; results in the same order with sums 370..373.
3. Sequence wrap:
   - Stimulus: requester 2 alone, 40 back-to-back ops (a = i, b = 4).
   - Required: `res_seq` wraps 31 -> 0; err stays 0; all sums i+4.
4. Flush with a full pipeline:
   - Stimulus: 5 ops in flight, then `flush` = 1.
   - Required: `req_ready` = 0 immediately; five results still delivered; `flush_done` = 1 one cycle after the fifth `res_valid`; back to RUN a cycle after `flush` drops.
5. Protocol error:
   - Stimulus: bench adder model emits `xout` = 8'h85 with nothing in flight.
   - Required: `err` = 1 next edge and stays 1 until reset.
6. Reset mid-stream:
   - Stimulus: `rst` low for 1 cycle during traffic.
   - Required: all outputs 0 asynchronously; no `res_valid` after release until new issues; next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared definitions for the adder round-robin scheduler.
//   - Tag field positions for the adder's 8-bit pass-through tag
//     (bit 7 valid, [6:5] requester id, [4:0] sequence number).
//   - Scheduler FSM state encoding.
//   - make_tag(): packs id/seq into an issued (valid) tag.
package adder_sched_pkg;

    localparam int TAG_VLD   = 7;
    localparam int TAG_ID_HI = 6;
    localparam int TAG_ID_LO = 5;
    localparam int TAG_SEQ_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sched_state_e;

    function automatic logic [7:0] make_tag(input logic [1:0] id,
                                            input logic [TAG_SEQ_W-1:0] seq);
        return {1'b1, id, seq};
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector
//   ptr  : highest-priority index for this cycle
//   gnt  : one-hot grant (all zero when no request)
//   idx  : index of the granted requester
//   any  : at least one request present
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Scan from the farthest offset back towards ptr so the nearest
    // asserted request (in rotating order) is the one left standing.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int k;
            k = (int'(ptr) + i) % NREQ;
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = IW'(k);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one pipelined adder between NREQ requesters.
//   clk, rst            : clock, async active-low reset (shared with adder)
//   req_valid/req_ready : per-requester handshake, req_ready one-hot
//   req_a, req_b        : packed operands, requester k at [k*W +: W]
//   add_a/add_b/add_xin : to adder ai/bi/xin (zeros = bubble)
//   add_si/add_xout     : from adder si/xout
//   res_*               : registered result port, no backpressure
//   flush/flush_done    : drain handshake
//   busy                : operations in flight or not in RUN
//   err                 : sticky tag-protocol error
module adder_arbiter
    import adder_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int LAT  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic [7:0]        add_xin,
    input  logic [W-1:0]      add_si,
    input  logic [7:0]        add_xout,
    output logic              res_valid,
    output logic [1:0]        res_id,
    output logic [4:0]        res_seq,
    output logic [W-1:0]      res_sum,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy,
    output logic              err
);

    localparam int IW = 2;                 // id width fixed by the tag
    localparam int CW = $clog2(LAT + 2);

    sched_state_e               state, state_nx;
    logic [IW-1:0]              ptr;
    logic [NREQ-1:0][TAG_SEQ_W-1:0] seq_tx, seq_rx;
    logic [CW-1:0]              inflight;

    logic [NREQ-1:0]            pick_gnt;
    logic [IW-1:0]              gnt_idx;
    logic                       pick_any;
    logic                       allow, xfer, ret;
    logic [IW-1:0]              ret_id;
    logic [TAG_SEQ_W-1:0]       ret_seq;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (gnt_idx),
        .any (pick_any)
    );

    // rst is folded in so req_ready/add_* read zero while reset is held.
    assign allow     = rst && (state == RUN) && !flush;
    assign req_ready = allow ? pick_gnt : '0;
    assign xfer      = allow && pick_any;

    assign add_a   = xfer ? req_a[gnt_idx*W +: W] : '0;
    assign add_b   = xfer ? req_b[gnt_idx*W +: W] : '0;
    assign add_xin = xfer ? make_tag(gnt_idx, seq_tx[gnt_idx]) : 8'h00;

    assign ret     = add_xout[TAG_VLD];
    assign ret_id  = add_xout[TAG_ID_HI:TAG_ID_LO];
    assign ret_seq = add_xout[TAG_SEQ_W-1:0];

    assign flush_done = (state == DONE);
    assign busy       = (inflight != '0) || (state != RUN);

    // Issue side: pointer and per-requester issue sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            seq_tx <= '0;
        end else if (xfer) begin
            ptr              <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            seq_tx[gnt_idx]  <= seq_tx[gnt_idx] + TAG_SEQ_W'(1);
        end
    end

    // Return side: result registers, expected sequence, error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_seq   <= '0;
            res_sum   <= '0;
            seq_rx    <= '0;
            err       <= 1'b0;
        end else begin
            res_valid <= ret;
            if (ret) begin
                res_id         <= ret_id;
                res_seq        <= ret_seq;
                res_sum        <= add_si;
                seq_rx[ret_id] <= seq_rx[ret_id] + TAG_SEQ_W'(1);
                if (inflight == '0 || ret_seq != seq_rx[ret_id])
                    err <= 1'b1;
            end
        end
    end

    // A spurious return with nothing in flight flags err but must not
    // wrap the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= '0;
        end else begin
            unique case ({xfer, ret})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   if (inflight != '0) inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (flush) state_nx = DRAIN;
            DRAIN:   if (inflight == '0 && !ret) state_nx = DONE;
            DONE:    if (!flush) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with an in-bench LAT-stage adder model.
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int LAT  = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_ready;
    logic [3:0][31:0] ra = '0;
    logic [3:0][31:0] rb = '0;
    logic [31:0]      add_a, add_b, add_si;
    logic [7:0]       add_xin, add_xout;
    logic             res_valid;
    logic [1:0]       res_id;
    logic [4:0]       res_seq;
    logic [31:0]      res_sum;
    logic             flush = 1'b0;
    logic             flush_done, busy, err;
    logic             inj = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(ra), .req_b(rb),
        .add_a(add_a), .add_b(add_b), .add_xin(add_xin),
        .add_si(add_si), .add_xout(add_xout),
        .res_valid(res_valid), .res_id(res_id), .res_seq(res_seq), .res_sum(res_sum),
        .flush(flush), .flush_done(flush_done), .busy(busy), .err(err)
    );

    // Adder model: LAT register stages, sharing the scheduler's reset.
    logic [LAT:1][7:0]  tp;
    logic [LAT:1][31:0] sp;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tp <= '0;
            sp <= '0;
        end else begin
            tp[1] <= add_xin;
            sp[1] <= add_a + add_b;
            for (int i = 2; i <= LAT; i++) begin
                tp[i] <= tp[i-1];
                sp[i] <= sp[i-1];
            end
        end
    end
    assign add_xout = inj ? 8'h85 : tp[LAT];
    assign add_si   = sp[LAT];

    typedef struct packed {
        logic [1:0]  id;
        logic [4:0]  seq;
        logic [31:0] sum;
    } res_t;
    res_t q[$];

    always @(negedge clk)
        if (res_valid) q.push_back('{id: res_id, seq: res_seq, sum: res_sum});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0; flush = 1'b0; inj = 1'b0;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        q.delete();
    endtask

    task automatic wait_results(input int n, input string tag);
        for (int c = 0; c < 40 && q.size() < n; c++) step();
        chk(tag, q.size(), n);
    endtask

    initial begin
        do_reset();

        // Reset state
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_seq", res_seq, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 0);

        // 1. Single issue: -10 + 10 from requester 0
        step();
        req_valid = 4'b0001; ra[0] = 32'(-10); rb[0] = 32'd10;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_xin", add_xin, 8'h80);
        chk("t1_add_a", add_a, 32'hFFFF_FFF6);
        chk("t1_add_b", add_b, 32'd10);
        step();
        req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t1_res_valid", res_valid, (c == 6));
            if (c != 6) step();
        end
        chk("t1_res_id", res_id, 0);
        chk("t1_res_seq", res_seq, 0);
        chk("t1_res_sum", res_sum, 0);
        chk("t1_busy", busy, 0);

        // 2. Full contention, strict rotation
        do_reset();
        for (int k = 0; k < 4; k++) begin ra[k] = 32'(352 + k); rb[k] = 32'd18; end
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            logic [7:0] ex;
            ex = 8'(8'h80 | ((c % 4) << 5) | (c / 4));
            @(negedge clk);
            chk("t2_ready", req_ready, 4'b0001 << (c % 4));
            chk("t2_xin", add_xin, ex);
            step();
        end
        req_valid = '0;
        wait_results(8, "t2_count");
        for (int i = 0; i < 8 && i < q.size(); i++) begin
            chk("t2_id", q[i].id, i % 4);
            chk("t2_seq", q[i].seq, i / 4);
            chk("t2_sum", q[i].sum, 370 + (i % 4));
        end

        // 3. Sequence wrap on requester 2
        do_reset();
        for (int i = 0; i < 40; i++) begin
            req_valid = 4'b0100; ra[2] = 32'(i); rb[2] = 32'd4;
            @(negedge clk);
            chk("t3_ready", req_ready, 4'b0100);
            step();
        end
        req_valid = '0;
        wait_results(40, "t3_count");
        for (int i = 0; i < 40 && i < q.size(); i++) begin
            chk("t3_id", q[i].id, 2);
            chk("t3_seq", q[i].seq, i % 32);
            chk("t3_sum", q[i].sum, i + 4);
        end
        chk("t3_err", err, 0);

        // 4. Flush with five operations in flight
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0001; ra[0] = 32'(i); rb[0] = 32'd100;
            @(negedge clk);
            chk("t4_ready_pre", req_ready, 4'b0001);
            step();
        end
        flush = 1'b1;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            chk("t4_ready_flush", req_ready, 0);
            chk("t4_xin_flush", add_xin, 0);
            chk("t4_flush_done", flush_done, (c >= 11));
            chk("t4_res_valid", res_valid, (c >= 6 && c <= 10));
            if (c >= 6 && c <= 10) begin
                chk("t4_res_seq", res_seq, c - 6);
                chk("t4_res_sum", res_sum, 100 + c - 6);
            end
            step();
        end
        flush = 1'b0;
        @(negedge clk);
        chk("t4_ready_done", req_ready, 0);
        chk("t4_done_hold", flush_done, 1);
        step();
        @(negedge clk);
        chk("t4_ready_run", req_ready, 4'b0001);
        chk("t4_done_clr", flush_done, 0);
        chk("t4_err", err, 0);

        // 5. Spurious return raises sticky err
        do_reset();
        inj = 1'b1;
        @(negedge clk);
        chk("t5_err_before", err, 0);
        step();
        inj = 1'b0;
        @(negedge clk);
        chk("t5_err_set", err, 1);
        chk("t5_res_valid", res_valid, 1);
        for (int c = 0; c < 3; c++) step();
        @(negedge clk);
        chk("t5_err_sticky", err, 1);
        do_reset();
        #1;
        chk("t5_err_reset", err, 0);

        // 6. Reset in the middle of traffic
        for (int k = 0; k < 4; k++) begin ra[k] = 32'(352 + k); rb[k] = 32'd18; end
        req_valid = 4'hF;
        for (int c = 0; c < 7; c++) step();
        @(negedge clk);
        chk("t6_res_valid_pre", res_valid, 1);
        step();
        rst = 1'b0;
        #1;
        chk("t6_rst_res_valid", res_valid, 0);
        chk("t6_rst_res_id", res_id, 0);
        chk("t6_rst_res_seq", res_seq, 0);
        chk("t6_rst_res_sum", res_sum, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_xin", add_xin, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_flush_done", flush_done, 0);
        chk("t6_rst_err", err, 0);
        step();
        rst = 1'b1;
        #1;
        chk("t6_first_grant", req_ready, 4'b0001);
        chk("t6_first_xin", add_xin, 8'h80);
        step();
        req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("t6_res_valid", res_valid, (c == 6));
            if (c != 6) step();
        end
        chk("t6_res_id", res_id, 0);
        chk("t6_res_sum", res_sum, 370);
        chk("t6_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
